// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready on both sides, per-word bit order
// selection and zero-bubble back-to-back loading on the last bit of a word.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ord_q, ord_d;
  logic             done_q, done_d;

  logic xfer;
  logic last_bit;
  logic accept;

  always_comb begin
    xfer       = (state_q == SHIFT) && ser_ready;
    last_bit   = (cnt_q == LAST_CNT);
    load_ready = (state_q == IDLE) || (xfer && last_bit);
    accept     = load_valid && load_ready;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          w_d     = din;
          ord_d   = msb_first;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (!last_bit) begin
            w_d   = ord_q ? {w_q[WIDTH-2:0], 1'b0} : {1'b0, w_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            done_d = 1'b1;
            // A word waiting on the last bit is taken without an idle cycle.
            if (accept) begin
              w_d   = din;
              ord_d = msb_first;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      ord_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      done_q  <= done_d;
    end
  end

  assign ser_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign ser_out   = (state_q == SHIFT) && (ord_q ? w_q[WIDTH-1] : w_q[0]);
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: 8-bit and 16-bit instances, directed words
// with hand-written bit sequences, done-pulse tracking and load/stall checks.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  din8  = '0;
  logic        msb8  = 1'b0, lv8  = 1'b0, rdy8  = 1'b0;
  logic        lr8, so8, sv8, busy8, done8;
  logic [15:0] din16 = '0;
  logic        msb16 = 1'b0, lv16 = 1'b0, rdy16 = 1'b0;
  logic        lr16, so16, sv16, busy16, done16;

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .msb_first(msb8), .load_valid(lv8),
    .load_ready(lr8), .ser_out(so8), .ser_valid(sv8), .ser_ready(rdy8),
    .busy(busy8), .done(done8)
  );

  piso_serializer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .din(din16), .msb_first(msb16), .load_valid(lv16),
    .load_ready(lr16), .ser_out(so16), .ser_valid(sv16), .ser_ready(rdy16),
    .busy(busy16), .done(done16)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic pend8  = 1'b0;
  logic pend16 = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // seq is written in transfer order: seq[n-1] is the first bit on the wire.
  task automatic push_seq(input int sel, input logic [31:0] seq, input int n,
                          input bit mark_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = seq[n-1-i];
      e.last = mark_last && (i == n - 1);
      if (sel == 8) q8.push_back(e);
      else          q16.push_back(e);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expected bit per accepted transfer; done must follow a last bit.
  always @(negedge clk) begin
    exp_t e;
    chk1("done8", done8, pend8);
    if (!rst && sv8 && rdy8) begin
      if (q8.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL bit8: unexpected transfer of %b, no bit expected at %0t", so8, $time);
        pend8 = 1'b0;
      end else begin
        e = q8.pop_front();
        chk1("bit8", so8, e.b);
        pend8 = e.last;
      end
    end else begin
      pend8 = 1'b0;
    end

    chk1("done16", done16, pend16);
    if (!rst && sv16 && rdy16) begin
      if (q16.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL bit16: unexpected transfer of %b, no bit expected at %0t", so16, $time);
        pend16 = 1'b0;
      end else begin
        e = q16.pop_front();
        chk1("bit16", so16, e.b);
        pend16 = e.last;
      end
    end else begin
      pend16 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk1("rst_ser_valid", sv8, 1'b0);
    chk1("rst_busy", busy8, 1'b0);
    chk1("rst_done", done8, 1'b0);
    chk1("rst_load_ready", lr8, 1'b1);
    chk1("rst_ser_out", so8, 1'b0);
    chk1("rst16_load_ready", lr16, 1'b1);
    chk1("rst16_busy", busy16, 1'b0);

    // LSB-first 0xB4; msb_first toggled mid-word must not matter
    rdy8 = 1'b1; din8 = 8'hB4; msb8 = 1'b0; lv8 = 1'b1;
    push_seq(8, 32'b00101101, 8, 1'b1);
    cyc(1);
    lv8 = 1'b0; msb8 = 1'b1;
    chk1("lsb_busy", busy8, 1'b1);
    chk1("lsb_first_bit", so8, 1'b0);
    cyc(8);
    chk1("lsb_done", done8, 1'b1);
    chk1("lsb_idle", busy8, 1'b0);
    chk1("lsb_load_ready", lr8, 1'b1);
    cyc(1);
    chk1("lsb_done_off", done8, 1'b0);
    chki("lsb_queue", q8.size(), 0);

    // MSB-first 0xB4
    din8 = 8'hB4; msb8 = 1'b1; lv8 = 1'b1;
    push_seq(8, 32'b10110100, 8, 1'b1);
    cyc(1);
    lv8 = 1'b0; msb8 = 1'b0;
    cyc(8);
    chk1("msb_done", done8, 1'b1);
    cyc(1);
    chk1("msb_done_off", done8, 1'b0);
    chk1("msb_idle", sv8, 1'b0);
    chki("msb_queue", q8.size(), 0);

    // Stall on bit 2 of 0xC3 with an ignored load of 0xFF
    din8 = 8'hC3; msb8 = 1'b0; lv8 = 1'b1;
    push_seq(8, 32'b11000011, 8, 1'b1);
    cyc(1);
    lv8 = 1'b0;
    cyc(1);
    rdy8 = 1'b0; lv8 = 1'b1; din8 = 8'hFF; msb8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1("stall_ser_out", so8, 1'b1);
      chk1("stall_load_ready", lr8, 1'b0);
      chk1("stall_valid", sv8, 1'b1);
      cyc(1);
    end
    chk1("stall_ser_out_end", so8, 1'b1);
    rdy8 = 1'b1; lv8 = 1'b0;
    cyc(7);
    chk1("stall_done", done8, 1'b1);
    chk1("stall_idle", busy8, 1'b0);
    cyc(1);
    chki("stall_queue", q8.size(), 0);

    // Back-to-back 0x01 then 0x80, load_valid held high throughout
    din8 = 8'h01; msb8 = 1'b0; lv8 = 1'b1;
    push_seq(8, 32'b10000000, 8, 1'b1);
    cyc(1);
    din8 = 8'h80;
    push_seq(8, 32'b00000001, 8, 1'b1);
    cyc(7);
    chk1("b2b_load_ready_last", lr8, 1'b1);
    cyc(1);
    lv8 = 1'b0;
    chk1("b2b_done1", done8, 1'b1);
    chk1("b2b_busy_mid", busy8, 1'b1);
    chk1("b2b_valid_mid", sv8, 1'b1);
    chk1("b2b_second_first_bit", so8, 1'b0);
    cyc(8);
    chk1("b2b_done2", done8, 1'b1);
    chk1("b2b_idle", busy8, 1'b0);
    cyc(1);
    chki("b2b_queue", q8.size(), 0);
    rdy8 = 1'b0;

    // WIDTH=16: reset after three bits of 0xA5F0, then full MSB-first word
    rdy16 = 1'b1; din16 = 16'hA5F0; msb16 = 1'b0; lv16 = 1'b1;
    push_seq(16, 32'b000, 3, 1'b0);
    cyc(1);
    lv16 = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk1("abort_busy", busy16, 1'b0);
    chk1("abort_valid", sv16, 1'b0);
    chk1("abort_load_ready", lr16, 1'b1);
    chk1("abort_done", done16, 1'b0);
    chk1("abort_ser_out", so16, 1'b0);
    cyc(1);
    chk1("abort_done_late", done16, 1'b0);
    chki("abort_queue", q16.size(), 0);

    din16 = 16'hA5F0; msb16 = 1'b1; lv16 = 1'b1;
    push_seq(16, 32'b1010010111110000, 16, 1'b1);
    cyc(1);
    lv16 = 1'b0;
    cyc(16);
    chk1("w16_done", done16, 1'b1);
    chk1("w16_idle", busy16, 1'b0);
    cyc(1);
    chk1("w16_done_off", done16, 1'b0);
    chki("w16_queue", q16.size(), 0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register, successor to the team's fixed 8-bit right-shift register.
- Accepts a WIDTH-bit word through a valid/ready load port and emits it one bit per transfer on a valid/ready serial port.
- Bit order (LSB-first or MSB-first) is selected per word.
- Sits between register-file/ALU outputs and bit-serial consumers (serial links, bit-serial datapaths in lab assignments).

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- din  input  WIDTH  parallel word to serialise.
- msb_first  input  1  bit order for the word; sampled only when a load is accepted (1 = MSB-first, 0 = LSB-first).
- load_valid  input  1  din/msb_first are valid.
- load_ready  output  1  block can accept a word this cycle; combinational.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  consumer takes ser_out this cycle.
- busy  output  1  a word is being shifted out.
- done  output  1  one-cycle pulse after the last bit of a word transfers.

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high, with priority over all other inputs.
- Reset values: state=IDLE, shift register=0, counter=0, order flag=0, ser_valid=0, ser_out=0, busy=0, done=0, load_ready=1 (combinational, follows state).
- Reset mid-word: the word is abandoned with no done pulse. On the next cycle the block is IDLE with load_ready=1.
- Load acceptance: load_valid && load_ready at a rising edge.
- On acceptance:
  - W <= din.
  - ord <= msb_first.
  - cnt <= 0.
  - state <= SHIFT.
- Latency: first bit is visible on ser_out in the cycle after acceptance.

States:
- IDLE:
  - load_ready=1, ser_valid=0, busy=0, ser_out=0.
  - Goes to SHIFT on acceptance.
- SHIFT:
  - ser_valid=1, busy=1.
  - ser_out = ord ? W[WIDTH-1] : W[0].
  - A transfer occurs when ser_valid && ser_ready.
  - On a transfer with cnt<WIDTH-1:
    - LSB-first: W <= {1'b0, W[WIDTH-1:1]}.
    - MSB-first: W <= {W[WIDTH-2:0], 1'b0}.
    - cnt <= cnt+1.
  - On a transfer with cnt==WIDTH-1 (last bit):
    - done <= 1 for exactly the next cycle.
    - If load_valid is high in the same cycle, the new word is accepted and the state stays SHIFT. This is back-to-back operation with zero bubble: the first bit of the new word appears in the very next cycle.
    - Otherwise the state goes to IDLE.
  - With ser_ready=0, W, cnt and ser_out hold indefinitely (stall). No timeout.

load_ready:
- Defined as (state==IDLE) || (state==SHIFT && ser_ready && cnt==WIDTH-1).
- load_valid in any other SHIFT cycle is ignored. din is not captured and the word in flight is not corrupted.

Other rules:
- msb_first changes outside a load acceptance have no effect on the word in flight.
- Vacated bit positions are always filled with 0.
- Each accepted word produces exactly WIDTH transfers, then one done pulse.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then release -> ser_valid=0, busy=0, done=0, load_ready=1, ser_out=0.
- LSB-first, WIDTH=8: load din=8'hB4, msb_first=0, ser_ready=1 -> from the next cycle ser_out = 0,0,1,0,1,1,0,1 on 8 consecutive cycles; done high the cycle after the 8th bit; then IDLE.
- MSB-first: load din=8'hB4, msb_first=1 -> ser_out = 1,0,1,1,0,1,0,0; done pulse once.
- Stall and ignored load: load 8'hC3 LSB-first, drop ser_ready for 3 cycles after the 2nd bit, and assert load_valid with din=8'hFF during the stall -> ser_out holds 1 through the stall; sequence completes as 1,1,0,0,0,0,1,1; 8'hFF not captured; load_ready=0 throughout.
- Back-to-back: hold load_valid with 8'h01 then 8'h80 (both LSB-first), ser_ready=1 -> 16 contiguous valid bits: 1,0×7, then 0×7,1; done pulses after bit 8 and after bit 16; no idle gap.
- Reset mid-word and WIDTH=16 instance: assert rst after 3 bits of 16'hA5F0 -> next cycle IDLE, no done pulse. Reload 16'hA5F0 MSB-first -> 16 bits 1010010111110000, done once.
